// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
//   Shared types and helpers for the BCD time-unit counters of the clock chain.
//   - bcd_digit_t / bcd2_t : one BCD digit and a packed two-digit BCD value
//   - rpt_state_t          : states of the optional auto-repeat FSM
//   - bin_to_bcd2()        : binary 0..99 to two-digit BCD (used on constants)
//   - bcd2_legal()         : both nibbles decimal and value inside [lo, hi]
// -----------------------------------------------------------------------------
package clock_pkg;

   typedef logic [3:0] bcd_digit_t;
   typedef logic [7:0] bcd2_t;

   typedef enum logic [1:0] {
      RPT_IDLE   = 2'd0,
      RPT_DELAY  = 2'd1,
      RPT_REPEAT = 2'd2
   } rpt_state_t;

   function automatic bcd2_t bin_to_bcd2(input int unsigned v);
      bcd_digit_t tens;
      bcd_digit_t units;
      tens  = bcd_digit_t'((v / 32'd10) % 32'd10);
      units = bcd_digit_t'(v % 32'd10);
      return {tens, units};
   endfunction

   // Legal BCD codes compare in the same order as their decimal values,
   // so the range check can be done directly on the packed byte.
   function automatic logic bcd2_legal(input bcd2_t v, input bcd2_t lo, input bcd2_t hi);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/bcd2_step.sv
// -----------------------------------------------------------------------------
// bcd2_step
//   Combinational +1 / -1 step of a two-digit BCD value inside [lo_i, hi_i],
//   wrapping at both ends. Shared by the run-mode tick and set-mode up/down.
// Ports
//   v_i       : current value (legal BCD, inside range)
//   dir_i     : 1 = increment, 0 = decrement
//   lo_i/hi_i : range limits in BCD
//   nxt_o     : stepped value
//   wrapped_o : 1 when the step wrapped (hi->lo going up, lo->hi going down)
// -----------------------------------------------------------------------------
module bcd2_step
   import clock_pkg::*;
(
   input  logic [7:0] v_i,
   input  logic       dir_i,
   input  logic [7:0] lo_i,
   input  logic [7:0] hi_i,
   output logic [7:0] nxt_o,
   output logic       wrapped_o
);

   // BCD increment/decrement with carry/borrow between the digits
   always_comb begin
      nxt_o     = v_i;
      wrapped_o = 1'b0;
      if (dir_i) begin
         if (v_i == hi_i) begin
            nxt_o     = lo_i;
            wrapped_o = 1'b1;
         end else if (v_i[3:0] >= 4'd9) begin
            nxt_o = {v_i[7:4] + 4'd1, 4'd0};
         end else begin
            nxt_o = {v_i[7:4], v_i[3:0] + 4'd1};
         end
      end else begin
         if (v_i == lo_i) begin
            nxt_o     = hi_i;
            wrapped_o = 1'b1;
         end else if (v_i[3:0] == 4'd0) begin
            nxt_o = {v_i[7:4] - 4'd1, 4'd9};
         end else begin
            nxt_o = {v_i[7:4], v_i[3:0] - 4'd1};
         end
      end
   end

endmodule

// File: rtl/bcd_unit_counter.sv
// -----------------------------------------------------------------------------
// bcd_unit_counter
//   Two-digit BCD time-unit counter (seconds, minutes, 24h or 12h hours).
//   Run mode counts on tick and emits TC on the MAX->MIN wrap; set mode steps
//   on rising edges of up/down with wrap both ways; load takes a preset value
//   with range checking. Priority: reset > load > set-mode step > tick.
// Configuration
//   AUTO_REPEAT_EN : when defined, holding a single button in set mode
//                    auto-repeats after REPEAT_DELAY cycles, then every
//                    REPEAT_PERIOD cycles. Undefined: edge stepping only.
// Ports
//   clk      : clock, all logic on posedge
//   reset    : synchronous active-high reset
//   tick     : one-cycle count enable from the lower stage
//   set_ena  : 1 = set mode, 0 = run mode
//   up/down  : synchronised, debounced button levels
//   load     : one-cycle parallel-load strobe
//   load_val : BCD value to load
//   BCD_out  : current value (registered)
//   TC       : one-cycle pulse on run-mode wrap (registered)
//   load_err : one-cycle pulse when load_val was rejected (registered)
// -----------------------------------------------------------------------------
module bcd_unit_counter
   import clock_pkg::*;
#(
   parameter int unsigned MOD_N         = 24,
   parameter int unsigned MIN_VAL       = 0,
   parameter int unsigned REPEAT_DELAY  = 500,
   parameter int unsigned REPEAT_PERIOD = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       set_ena,
   input  logic       up,
   input  logic       down,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [7:0] BCD_out,
   output logic       TC,
   output logic       load_err
);

   localparam bcd2_t LO_BCD = bin_to_bcd2(MIN_VAL);
   localparam bcd2_t HI_BCD = bin_to_bcd2(MIN_VAL + MOD_N - 32'd1);

   logic [7:0] val_q, val_d;
   logic       tc_q, tc_d;
   logic       err_q, err_d;
   logic       up_q, down_q;

   logic       up_rise_s, down_rise_s;
   logic       edge_step_s;
   logic       rpt_step_s;
   logic       rpt_dir_s;
   logic       step_dir_s;
   logic [7:0] step_nxt_s;
   logic       step_wrap_s;

   assign up_rise_s   = up & ~up_q;
   assign down_rise_s = down & ~down_q;
   // simultaneous rises cancel out
   assign edge_step_s = set_ena & (up_rise_s ^ down_rise_s);
   assign step_dir_s  = set_ena ? (rpt_step_s ? rpt_dir_s : up_rise_s) : 1'b1;

   bcd2_step u_step (
      .v_i       (val_q),
      .dir_i     (step_dir_s),
      .lo_i      (LO_BCD),
      .hi_i      (HI_BCD),
      .nxt_o     (step_nxt_s),
      .wrapped_o (step_wrap_s)
   );

`ifdef AUTO_REPEAT_EN
   localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int          CNT_W   = $clog2(RPT_MAX);
   // Counter runs down to zero; loading N-1 yields a step N cycles later.
   localparam logic [CNT_W-1:0] DLY_LD = CNT_W'(REPEAT_DELAY - 32'd1);
   localparam logic [CNT_W-1:0] PER_LD = CNT_W'(REPEAT_PERIOD - 32'd1);

   rpt_state_t       rpt_state_q;
   logic [CNT_W-1:0] rpt_cnt_q;
   logic             rpt_dir_q;
   logic             rpt_exit_s;
   logic             rpt_start_s;

   assign rpt_exit_s  = load | ~set_ena | (up & down) | (rpt_dir_q ? ~up : ~down);
   assign rpt_start_s = edge_step_s & ~load & ~(up & down);
   assign rpt_step_s  = (rpt_state_q != RPT_IDLE) & ~rpt_exit_s & (rpt_cnt_q == {CNT_W{1'b0}});
   assign rpt_dir_s   = rpt_dir_q;

   // Auto-repeat FSM: IDLE -> DELAY on an edge step, DELAY -> REPEAT on first repeat
   always_ff @(posedge clk) begin
      if (reset) begin
         rpt_state_q <= RPT_IDLE;
         rpt_cnt_q   <= {CNT_W{1'b0}};
         rpt_dir_q   <= 1'b0;
      end else begin
         case (rpt_state_q)
            RPT_IDLE: begin
               if (rpt_start_s) begin
                  rpt_state_q <= RPT_DELAY;
                  rpt_cnt_q   <= DLY_LD;
                  rpt_dir_q   <= up_rise_s;
               end
            end
            RPT_DELAY: begin
               if (rpt_exit_s) begin
                  rpt_state_q <= RPT_IDLE;
                  rpt_cnt_q   <= {CNT_W{1'b0}};
               end else if (rpt_cnt_q == {CNT_W{1'b0}}) begin
                  rpt_state_q <= RPT_REPEAT;
                  rpt_cnt_q   <= PER_LD;
               end else begin
                  rpt_cnt_q   <= rpt_cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            RPT_REPEAT: begin
               if (rpt_exit_s) begin
                  rpt_state_q <= RPT_IDLE;
                  rpt_cnt_q   <= {CNT_W{1'b0}};
               end else if (rpt_cnt_q == {CNT_W{1'b0}}) begin
                  rpt_cnt_q   <= PER_LD;
               end else begin
                  rpt_cnt_q   <= rpt_cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               rpt_state_q <= RPT_IDLE;
               rpt_cnt_q   <= {CNT_W{1'b0}};
            end
         endcase
      end
   end
`else
   logic unused_rpt_cfg_s;

   assign rpt_step_s       = 1'b0;
   assign rpt_dir_s        = 1'b0;
   assign unused_rpt_cfg_s = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

   // Next value: load, then set-mode step, then run-mode tick
   always_comb begin
      val_d = val_q;
      tc_d  = 1'b0;
      err_d = 1'b0;
      if (load) begin
         if (bcd2_legal(load_val, LO_BCD, HI_BCD)) begin
            val_d = load_val;
         end else begin
            val_d = LO_BCD;
            err_d = 1'b1;
         end
      end else if (set_ena) begin
         if (edge_step_s || rpt_step_s) begin
            val_d = step_nxt_s;
         end else begin
            val_d = val_q;
         end
      end else if (tick) begin
         val_d = step_nxt_s;
         tc_d  = step_wrap_s;
      end else begin
         val_d = val_q;
      end
   end

   // Value, output pulses and button history registers
   always_ff @(posedge clk) begin
      if (reset) begin
         val_q  <= LO_BCD;
         tc_q   <= 1'b0;
         err_q  <= 1'b0;
         up_q   <= 1'b0;
         down_q <= 1'b0;
      end else begin
         val_q  <= val_d;
         tc_q   <= tc_d;
         err_q  <= err_d;
         up_q   <= up;
         down_q <= down;
      end
   end

   assign BCD_out  = val_q;
   assign TC       = tc_q;
   assign load_err = err_q;

endmodule
